dispatch_stage: RTL and testbench
=================================

// Module: dispatch_stage
// PURPOSE
//  Parametrised decode-and-dispatch stage between the instruction queue and ROB/RS/LSB. Buffers fetched
//  instructions in a BUF_DEPTH FIFO and decodes the head (RV32I, plus RV32M when EN_RV32M=1). Resolves
//  operands from the register file, ROB and CDB, and issues one registered dispatch packet per cycle.
//  Adds flush, halt-state and CDB-bypass behaviour the single-cycle decoder lacks.
// PARAMETERS
//  ROB_WIDTH_BIT  3  ROB index width; ROB id 0 is never allocated, so a tag of 0 means "no dependency"
//  REG_ID_BIT     5  architectural register id width
//  BUF_DEPTH      2  input FIFO entries, power of two, >=2
//  EN_RV32M       0  1: decode MUL..REMU (opcode 0110011, func7=0000001) as op 40..47; 0: op 39
// PORTS
//  clk_in        in   1   clock
//  rst_in        in   1   asynchronous reset, active-high
//  rdy_in        in   1   low: every register holds its value
//  flush         in   1   misprediction: clear FIFO, drop dispatch, leave HALT
//  in_valid/in_ready in/out 1/1  instruction push handshake
//  in_pc, in_inst in  32/32  pushed instruction and its pc
//  rs1_id, rs2_id out REG_ID_BIT  combinational head source ids to regfile/ROB (0 if unused)
//  rsN_busy, rsN_value, rsN_re  in 1/32/ROB_WIDTH_BIT  regfile status (N=1,2)
//  rob_rsN_ready, rob_rsN_value in 1/32  ROB lookup of rsN_re
//  cdb_valid, cdb_rob_id, cdb_value in 1/ROB_WIDTH_BIT/32  same-cycle broadcast
//  rob_full, rob_free_id  in 1/ROB_WIDTH_BIT  ROB state; free id is tagged onto the dispatch
//  rs_full, lsb_full  in 1/1  unit back-pressure
//  disp_valid    out  1   one-cycle dispatch pulse
//  disp_unit     out  2   0=RS, 1=LSB, 2=ROB-only (illegal/halt)
//  disp_op       out  6   op code: 0..37 RV32I, 38 halt, 39 illegal, 40..47 RV32M
//  disp_rd, disp_rob_id  out REG_ID_BIT/ROB_WIDTH_BIT  destination register (0 if none), allocated ROB id
//  disp_imm, disp_pc     out 32/32  format-extended immediate (I/S/B/U/J), instruction pc
//  disp_j/vj/qj, disp_k/vk/qk  out 1/32/ROB_WIDTH_BIT  operand ready flag, value, tag
// BEHAVIOUR
//  Reset: FIFO empty, in_ready=1, state RUN, every disp_* output 0.
//  in_ready = !fifo_full && state==RUN. A push is never accepted into a full FIFO, even in a pop cycle.
//  Pointers are log2(BUF_DEPTH)+1 bits: full = MSBs differ and LSBs equal; pointers wrap naturally.
//  Dispatch fires when all hold: rdy_in, !flush, FIFO non-empty, state RUN, !rob_full, and the target unit
//    is not full (RS: rs_full; LSB: lsb_full; ROB-only: no unit check). Firing pops the head and
//    registers the packet; the next cycle has disp_valid=1. disp_valid=0 when nothing fires.
//  Latency: push in cycle T, earliest disp_valid in cycle T+2 (one cycle in FIFO, one output register).
//  Unit: loads/stores (op 10..17) -> LSB; ops 39/38 -> ROB-only; all others -> RS.
//  Sources: rs1 used by JALR, branch, load, store, ALU-I, ALU-R, M; rs2 by branch, store, ALU-R, M.
//    An unused operand, or source register x0, gives j=1, vj=0, qj=0.
//  Operand priority, per source: !busy -> regfile value; else rob_ready -> ROB value;
//    else cdb_valid && cdb_rob_id==re -> cdb_value, ready; else j=0, qj=re, vj=0.
//  disp_rd = rd for LUI/AUIPC/JAL/JALR/load/ALU-I/ALU-R/M; 0 for branch, store, halt, illegal.
//  Halt: inst 32'h0ff00513 gives op 38. After it dispatches, state=HALT: no dispatch, in_ready=0.
//    The FIFO is kept until flush. Only flush returns the state to RUN.
//  flush: FIFO emptied next edge; disp_valid=0 next cycle; a same-cycle push is dropped.
//    flush overrides dispatch.
//  Asynchronous reset mid-operation: immediately returns to the reset state; any in-flight packet is lost.
//  rdy_in=0: FIFO, state and disp_* hold, including a disp_valid=1 already on the outputs.
// TESTING
//  1. Reset, push ADDI x5,x0,7 (0x00700293), regs idle -> 2 cycles later: disp_valid=1, unit=0, op=18,
//     rd=5, imm=7, j=1, vj=0, k=1.
//  2. Push ADD x3,x1,x2, rs1 busy re=2, rob not ready, cdb_valid id=2 val=0x55, rs2 busy re=4 not ready
//     -> j=1 vj=0x55; k=0 qk=4.
//  3. Hold rob_full=1 and push BUF_DEPTH instructions -> in_ready=0, no disp_valid.
//     Release -> instructions dispatch in order on consecutive cycles.
//  4. Push LW, then set lsb_full=1 -> no dispatch. Clear it -> unit=1, op=12, rd per inst, rs2_id=0.
//  5. Push 0x0ff00513, then ADDI -> only halt dispatches (unit=2, op=38). Then flush -> FIFO empty,
//     in_ready=1, a new push dispatches.
//  6. EN_RV32M=1, push MUL x1,x2,x3 (0x023100b3) -> op=40, unit=0. With EN_RV32M=0 -> op=39,
//     unit=2, rd=0.

Source files
------------

// File: rtl/dispatch_stage.sv
// Decode-and-dispatch stage: small instruction FIFO, RV32I(+M) decode of the head,
// operand resolution from regfile/ROB/CDB, and one registered dispatch packet per cycle.
module dispatch_stage #(
    parameter int ROB_WIDTH_BIT = 3,
    parameter int REG_ID_BIT    = 5,
    parameter int BUF_DEPTH     = 2,
    parameter bit EN_RV32M      = 1'b0
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_inst,
    output logic [REG_ID_BIT-1:0]    rs1_id,
    output logic [REG_ID_BIT-1:0]    rs2_id,
    input  logic                     rs1_busy,
    input  logic [31:0]              rs1_value,
    input  logic [ROB_WIDTH_BIT-1:0] rs1_re,
    input  logic                     rs2_busy,
    input  logic [31:0]              rs2_value,
    input  logic [ROB_WIDTH_BIT-1:0] rs2_re,
    input  logic                     rob_rs1_ready,
    input  logic [31:0]              rob_rs1_value,
    input  logic                     rob_rs2_ready,
    input  logic [31:0]              rob_rs2_value,
    input  logic                     cdb_valid,
    input  logic [ROB_WIDTH_BIT-1:0] cdb_rob_id,
    input  logic [31:0]              cdb_value,
    input  logic                     rob_full,
    input  logic [ROB_WIDTH_BIT-1:0] rob_free_id,
    input  logic                     rs_full,
    input  logic                     lsb_full,
    output logic                     disp_valid,
    output logic [1:0]               disp_unit,
    output logic [5:0]               disp_op,
    output logic [REG_ID_BIT-1:0]    disp_rd,
    output logic [ROB_WIDTH_BIT-1:0] disp_rob_id,
    output logic [31:0]              disp_imm,
    output logic [31:0]              disp_pc,
    output logic                     disp_j,
    output logic [31:0]              disp_vj,
    output logic [ROB_WIDTH_BIT-1:0] disp_qj,
    output logic                     disp_k,
    output logic [31:0]              disp_vk,
    output logic [ROB_WIDTH_BIT-1:0] disp_qk
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int OPND_W = ROB_WIDTH_BIT + 33;
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;
    localparam logic [31:0] HALT_INST = 32'h0ff00513;

    logic [PTR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [0:0]     state_q, state_d;
    logic [31:0]    buf_inst_q [BUF_DEPTH];
    logic [31:0]    buf_pc_q   [BUF_DEPTH];

    logic                     disp_valid_q, disp_valid_d;
    logic [1:0]               disp_unit_q, disp_unit_d;
    logic [5:0]               disp_op_q, disp_op_d;
    logic [REG_ID_BIT-1:0]    disp_rd_q, disp_rd_d;
    logic [ROB_WIDTH_BIT-1:0] disp_rob_id_q, disp_rob_id_d;
    logic [31:0]              disp_imm_q, disp_imm_d, disp_pc_q, disp_pc_d;
    logic [OPND_W-1:0]        opnd_j_q, opnd_j_d, opnd_k_q, opnd_k_d;

    logic        empty, full, push, fire, unit_ok;
    logic [31:0] inst, head_pc, imm;
    logic [5:0]  op;
    logic [1:0]  unit;
    logic        use1, use2, has_rd;
    logic [OPND_W-1:0] opnd_j, opnd_k;

    // Returns {ready, value, tag}; x0 or an unused source is always ready with value 0.
    function automatic logic [OPND_W-1:0] resolve(
        input logic used, input logic [4:0] rid, input logic busy, input logic [31:0] rf_val,
        input logic [ROB_WIDTH_BIT-1:0] re, input logic rob_rdy, input logic [31:0] rob_val,
        input logic cvalid, input logic [ROB_WIDTH_BIT-1:0] cid, input logic [31:0] cval);
        logic [OPND_W-1:0] r;
        if (!used || rid == 5'd0) r = {1'b1, 32'd0, {ROB_WIDTH_BIT{1'b0}}};
        else if (!busy)           r = {1'b1, rf_val, {ROB_WIDTH_BIT{1'b0}}};
        else if (rob_rdy)         r = {1'b1, rob_val, {ROB_WIDTH_BIT{1'b0}}};
        else if (cvalid && cid == re) r = {1'b1, cval, {ROB_WIDTH_BIT{1'b0}}};
        else                      r = {1'b0, 32'd0, re};
        return r;
    endfunction

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign in_ready = !full && (state_q == ST_RUN);
    assign push     = rdy_in && !flush && in_valid && in_ready;
    assign inst     = buf_inst_q[rd_ptr_q[PTR_W-1:0]];
    assign head_pc  = buf_pc_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        op = 6'd39; use1 = 1'b0; use2 = 1'b0; has_rd = 1'b0; imm = 32'd0;
        case (inst[6:0])
            7'b0110111: begin op = 6'd0; has_rd = 1'b1; imm = {inst[31:12], 12'd0}; end
            7'b0010111: begin op = 6'd1; has_rd = 1'b1; imm = {inst[31:12], 12'd0}; end
            7'b1101111: begin
                op = 6'd2; has_rd = 1'b1;
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            7'b1100111: begin
                if (inst[14:12] == 3'b000) op = 6'd3;
                use1 = 1'b1; has_rd = 1'b1; imm = {{20{inst[31]}}, inst[31:20]};
            end
            7'b1100011: begin
                case (inst[14:12])
                    3'b000: op = 6'd4;  3'b001: op = 6'd5;
                    3'b100: op = 6'd6;  3'b101: op = 6'd7;
                    3'b110: op = 6'd8;  3'b111: op = 6'd9;
                    default: op = 6'd39;
                endcase
                use1 = 1'b1; use2 = 1'b1;
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            7'b0000011: begin
                case (inst[14:12])
                    3'b000: op = 6'd10; 3'b001: op = 6'd11; 3'b010: op = 6'd12;
                    3'b100: op = 6'd13; 3'b101: op = 6'd14;
                    default: op = 6'd39;
                endcase
                use1 = 1'b1; has_rd = 1'b1; imm = {{20{inst[31]}}, inst[31:20]};
            end
            7'b0100011: begin
                case (inst[14:12])
                    3'b000: op = 6'd15; 3'b001: op = 6'd16; 3'b010: op = 6'd17;
                    default: op = 6'd39;
                endcase
                use1 = 1'b1; use2 = 1'b1; imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            7'b0010011: begin
                case (inst[14:12])
                    3'b000: op = 6'd18; 3'b010: op = 6'd19; 3'b011: op = 6'd20;
                    3'b100: op = 6'd21; 3'b110: op = 6'd22; 3'b111: op = 6'd23;
                    3'b001: op = (inst[31:25] == 7'b0000000) ? 6'd24 : 6'd39;
                    3'b101: op = (inst[31:25] == 7'b0000000) ? 6'd25 :
                                 (inst[31:25] == 7'b0100000) ? 6'd26 : 6'd39;
                    default: op = 6'd39;
                endcase
                use1 = 1'b1; has_rd = 1'b1; imm = {{20{inst[31]}}, inst[31:20]};
            end
            7'b0110011: begin
                if (inst[31:25] == 7'b0000000) begin
                    case (inst[14:12])
                        3'b000: op = 6'd27; 3'b001: op = 6'd29; 3'b010: op = 6'd30;
                        3'b011: op = 6'd31; 3'b100: op = 6'd32; 3'b101: op = 6'd33;
                        3'b110: op = 6'd35; default: op = 6'd36;
                    endcase
                end else if (inst[31:25] == 7'b0100000) begin
                    op = (inst[14:12] == 3'b000) ? 6'd28 : (inst[14:12] == 3'b101) ? 6'd34 : 6'd39;
                end else if (inst[31:25] == 7'b0000001 && EN_RV32M) begin
                    op = 6'd40 + {3'd0, inst[14:12]};
                end
                use1 = 1'b1; use2 = 1'b1; has_rd = 1'b1;
            end
            7'b0001111: op = 6'd37;
            default: op = 6'd39;
        endcase
        if (inst == HALT_INST) op = 6'd38;
        // Halt and illegal carry no operands and write no register.
        if (op == 6'd38 || op == 6'd39) begin
            use1 = 1'b0; use2 = 1'b0; has_rd = 1'b0;
        end
    end

    always_comb begin
        if (op >= 6'd10 && op <= 6'd17)      unit = 2'd1;
        else if (op == 6'd38 || op == 6'd39) unit = 2'd2;
        else                                 unit = 2'd0;
        unit_ok = (unit == 2'd0) ? !rs_full : (unit == 2'd1) ? !lsb_full : 1'b1;
        fire    = rdy_in && !flush && !empty && (state_q == ST_RUN) && !rob_full && unit_ok;
        rs1_id  = (use1 && !empty) ? REG_ID_BIT'(inst[19:15]) : '0;
        rs2_id  = (use2 && !empty) ? REG_ID_BIT'(inst[24:20]) : '0;
        opnd_j  = resolve(use1, inst[19:15], rs1_busy, rs1_value, rs1_re, rob_rs1_ready,
                          rob_rs1_value, cdb_valid, cdb_rob_id, cdb_value);
        opnd_k  = resolve(use2, inst[24:20], rs2_busy, rs2_value, rs2_re, rob_rs2_ready,
                          rob_rs2_value, cdb_valid, cdb_rob_id, cdb_value);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q; rd_ptr_d = rd_ptr_q; state_d = state_q;
        disp_valid_d = disp_valid_q; disp_unit_d = disp_unit_q; disp_op_d = disp_op_q;
        disp_rd_d = disp_rd_q; disp_rob_id_d = disp_rob_id_q; disp_imm_d = disp_imm_q;
        disp_pc_d = disp_pc_q; opnd_j_d = opnd_j_q; opnd_k_d = opnd_k_q;
        if (rdy_in) begin
            if (flush) begin
                rd_ptr_d     = wr_ptr_q;
                state_d      = ST_RUN;
                disp_valid_d = 1'b0;
            end else begin
                wr_ptr_d     = wr_ptr_q + {{PTR_W{1'b0}}, push};
                rd_ptr_d     = rd_ptr_q + {{PTR_W{1'b0}}, fire};
                disp_valid_d = fire;
                if (fire) begin
                    disp_unit_d   = unit;
                    disp_op_d     = op;
                    disp_rd_d     = has_rd ? REG_ID_BIT'(inst[11:7]) : '0;
                    disp_rob_id_d = rob_free_id;
                    disp_imm_d    = imm;
                    disp_pc_d     = head_pc;
                    opnd_j_d      = opnd_j;
                    opnd_k_d      = opnd_k;
                    if (op == 6'd38) state_d = ST_HALT;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0; rd_ptr_q <= '0; state_q <= ST_RUN;
            disp_valid_q <= 1'b0; disp_unit_q <= '0; disp_op_q <= '0; disp_rd_q <= '0;
            disp_rob_id_q <= '0; disp_imm_q <= '0; disp_pc_q <= '0;
            opnd_j_q <= '0; opnd_k_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; state_q <= state_d;
            disp_valid_q <= disp_valid_d; disp_unit_q <= disp_unit_d; disp_op_q <= disp_op_d;
            disp_rd_q <= disp_rd_d; disp_rob_id_q <= disp_rob_id_d; disp_imm_q <= disp_imm_d;
            disp_pc_q <= disp_pc_d; opnd_j_q <= opnd_j_d; opnd_k_q <= opnd_k_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            buf_inst_q[wr_ptr_q[PTR_W-1:0]] <= in_inst;
            buf_pc_q[wr_ptr_q[PTR_W-1:0]]   <= in_pc;
        end
    end

    assign disp_valid  = disp_valid_q;
    assign disp_unit   = disp_unit_q;
    assign disp_op     = disp_op_q;
    assign disp_rd     = disp_rd_q;
    assign disp_rob_id = disp_rob_id_q;
    assign disp_imm    = disp_imm_q;
    assign disp_pc     = disp_pc_q;
    assign {disp_j, disp_vj, disp_qj} = opnd_j_q;
    assign {disp_k, disp_vk, disp_qk} = opnd_k_q;
endmodule

// File: tb/tb_dispatch_stage.sv
// Directed bench for dispatch_stage; a second instance with RV32M enabled shares the stimulus.
module tb_dispatch_stage;
    logic clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, flush = 1'b0, in_valid = 1'b0;
    logic [31:0] in_pc = 32'd0, in_inst = 32'd0;
    logic rs1_busy = 1'b0, rs2_busy = 1'b0, rob_rs1_ready = 1'b0, rob_rs2_ready = 1'b0;
    logic [31:0] rs1_value = 32'hdead0001, rs2_value = 32'hdead0002;
    logic [31:0] rob_rs1_value = 32'd0, rob_rs2_value = 32'd0, cdb_value = 32'd0;
    logic [2:0] rs1_re = 3'd0, rs2_re = 3'd0, cdb_rob_id = 3'd0, rob_free_id = 3'd3;
    logic cdb_valid = 1'b0, rob_full = 1'b0, rs_full = 1'b0, lsb_full = 1'b0;

    logic in_ready, disp_valid, disp_j, disp_k;
    logic [4:0] rs1_id, rs2_id, disp_rd;
    logic [1:0] disp_unit;
    logic [5:0] disp_op;
    logic [2:0] disp_rob_id, disp_qj, disp_qk;
    logic [31:0] disp_imm, disp_pc, disp_vj, disp_vk;

    logic m_in_ready, m_disp_valid, m_disp_j, m_disp_k;
    logic [4:0] m_rs1_id, m_rs2_id, m_disp_rd;
    logic [1:0] m_disp_unit;
    logic [5:0] m_disp_op;
    logic [2:0] m_disp_rob_id, m_disp_qj, m_disp_qk;
    logic [31:0] m_disp_imm, m_disp_pc, m_disp_vj, m_disp_vk;

    int vecs = 0, miss = 0;

    always #5 clk_in = ~clk_in;

    dispatch_stage #(.ROB_WIDTH_BIT(3), .REG_ID_BIT(5), .BUF_DEPTH(2), .EN_RV32M(1'b0)) u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_busy(rs1_busy), .rs1_value(rs1_value), .rs1_re(rs1_re),
        .rs2_busy(rs2_busy), .rs2_value(rs2_value), .rs2_re(rs2_re),
        .rob_rs1_ready(rob_rs1_ready), .rob_rs1_value(rob_rs1_value),
        .rob_rs2_ready(rob_rs2_ready), .rob_rs2_value(rob_rs2_value),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
        .rob_full(rob_full), .rob_free_id(rob_free_id), .rs_full(rs_full), .lsb_full(lsb_full),
        .disp_valid(disp_valid), .disp_unit(disp_unit), .disp_op(disp_op), .disp_rd(disp_rd),
        .disp_rob_id(disp_rob_id), .disp_imm(disp_imm), .disp_pc(disp_pc),
        .disp_j(disp_j), .disp_vj(disp_vj), .disp_qj(disp_qj),
        .disp_k(disp_k), .disp_vk(disp_vk), .disp_qk(disp_qk));

    dispatch_stage #(.ROB_WIDTH_BIT(3), .REG_ID_BIT(5), .BUF_DEPTH(2), .EN_RV32M(1'b1)) u_dut_m (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .in_valid(in_valid), .in_ready(m_in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .rs1_id(m_rs1_id), .rs2_id(m_rs2_id),
        .rs1_busy(rs1_busy), .rs1_value(rs1_value), .rs1_re(rs1_re),
        .rs2_busy(rs2_busy), .rs2_value(rs2_value), .rs2_re(rs2_re),
        .rob_rs1_ready(rob_rs1_ready), .rob_rs1_value(rob_rs1_value),
        .rob_rs2_ready(rob_rs2_ready), .rob_rs2_value(rob_rs2_value),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
        .rob_full(rob_full), .rob_free_id(rob_free_id), .rs_full(rs_full), .lsb_full(lsb_full),
        .disp_valid(m_disp_valid), .disp_unit(m_disp_unit), .disp_op(m_disp_op),
        .disp_rd(m_disp_rd), .disp_rob_id(m_disp_rob_id), .disp_imm(m_disp_imm),
        .disp_pc(m_disp_pc), .disp_j(m_disp_j), .disp_vj(m_disp_vj), .disp_qj(m_disp_qj),
        .disp_k(m_disp_k), .disp_vk(m_disp_vk), .disp_qk(m_disp_qk));

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1; in_inst = inst; in_pc = pc;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        tick(); tick();
        rst_in = 1'b0;
        chk("rst_valid", {31'd0, disp_valid}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_op", {26'd0, disp_op}, 32'd0);
        chk("rst_imm", disp_imm, 32'd0);

        // 1: ADDI x5,x0,7
        push(32'h00700293, 32'h100);
        chk("addi_lat1", {31'd0, disp_valid}, 32'd0);
        tick();
        chk("addi_valid", {31'd0, disp_valid}, 32'd1);
        chk("addi_unit", {30'd0, disp_unit}, 32'd0);
        chk("addi_op", {26'd0, disp_op}, 32'd18);
        chk("addi_rd", {27'd0, disp_rd}, 32'd5);
        chk("addi_imm", disp_imm, 32'd7);
        chk("addi_pc", disp_pc, 32'h100);
        chk("addi_robid", {29'd0, disp_rob_id}, 32'd3);
        chk("addi_j", {31'd0, disp_j}, 32'd1);
        chk("addi_vj", disp_vj, 32'd0);
        chk("addi_k", {31'd0, disp_k}, 32'd1);
        tick();
        chk("addi_pulse", {31'd0, disp_valid}, 32'd0);

        // 2: ADD x3,x1,x2 with CDB bypass on rs1, rs2 still pending
        rs1_busy = 1'b1; rs1_re = 3'd2; cdb_valid = 1'b1; cdb_rob_id = 3'd2; cdb_value = 32'h55;
        rs2_busy = 1'b1; rs2_re = 3'd4;
        push(32'h002081b3, 32'h104);
        chk("add_rs1id", {27'd0, rs1_id}, 32'd1);
        chk("add_rs2id", {27'd0, rs2_id}, 32'd2);
        tick();
        chk("add_op", {26'd0, disp_op}, 32'd27);
        chk("add_rd", {27'd0, disp_rd}, 32'd3);
        chk("add_j", {31'd0, disp_j}, 32'd1);
        chk("add_vj", disp_vj, 32'h55);
        chk("add_k", {31'd0, disp_k}, 32'd0);
        chk("add_qk", {29'd0, disp_qk}, 32'd4);
        chk("add_vk", disp_vk, 32'd0);
        // 2b: regfile value on rs1, ROB value on rs2
        rs1_busy = 1'b0; cdb_valid = 1'b0; rob_rs2_ready = 1'b1; rob_rs2_value = 32'h77;
        push(32'h002081b3, 32'h108);
        tick();
        chk("add2_vj", disp_vj, 32'hdead0001);
        chk("add2_k", {31'd0, disp_k}, 32'd1);
        chk("add2_vk", disp_vk, 32'h77);
        rs2_busy = 1'b0; rob_rs2_ready = 1'b0;

        // 3: fill FIFO under rob_full, third push must be dropped
        rob_full = 1'b1;
        push(32'h00700293, 32'h200);
        push(32'h00900313, 32'h204);
        chk("full_ready", {31'd0, in_ready}, 32'd0);
        chk("full_valid", {31'd0, disp_valid}, 32'd0);
        push(32'h00b00393, 32'h208);
        chk("full_hold", {31'd0, disp_valid}, 32'd0);
        rob_full = 1'b0;
        tick();
        chk("order1_valid", {31'd0, disp_valid}, 32'd1);
        chk("order1_rd", {27'd0, disp_rd}, 32'd5);
        tick();
        chk("order2_valid", {31'd0, disp_valid}, 32'd1);
        chk("order2_rd", {27'd0, disp_rd}, 32'd6);
        chk("order2_imm", disp_imm, 32'd9);
        tick();
        chk("drop_third", {31'd0, disp_valid}, 32'd0);

        // 4: LW x8,4(x1) blocked by lsb_full
        lsb_full = 1'b1;
        push(32'h0040a403, 32'h300);
        tick();
        chk("lw_blocked", {31'd0, disp_valid}, 32'd0);
        chk("lw_rs1id", {27'd0, rs1_id}, 32'd1);
        chk("lw_rs2id", {27'd0, rs2_id}, 32'd0);
        lsb_full = 1'b0;
        tick();
        chk("lw_valid", {31'd0, disp_valid}, 32'd1);
        chk("lw_unit", {30'd0, disp_unit}, 32'd1);
        chk("lw_op", {26'd0, disp_op}, 32'd12);
        chk("lw_rd", {27'd0, disp_rd}, 32'd8);
        chk("lw_imm", disp_imm, 32'd4);
        chk("lw_vj", disp_vj, 32'hdead0001);

        // 5: halt, then ADDI behind it, then flush
        push(32'h0ff00513, 32'h400);
        push(32'h00700293, 32'h404);
        chk("halt_valid", {31'd0, disp_valid}, 32'd1);
        chk("halt_unit", {30'd0, disp_unit}, 32'd2);
        chk("halt_op", {26'd0, disp_op}, 32'd38);
        chk("halt_rd", {27'd0, disp_rd}, 32'd0);
        chk("halt_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("halt_stop1", {31'd0, disp_valid}, 32'd0);
        tick();
        chk("halt_stop2", {31'd0, disp_valid}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_valid", {31'd0, disp_valid}, 32'd0);
        tick();
        chk("flush_empty", {31'd0, disp_valid}, 32'd0);
        push(32'h00900313, 32'h500);
        tick();
        chk("post_flush_valid", {31'd0, disp_valid}, 32'd1);
        chk("post_flush_rd", {27'd0, disp_rd}, 32'd6);

        // rdy_in low holds a pending dispatch pulse
        push(32'h00700293, 32'h600);
        tick();
        rdy_in = 1'b0;
        tick();
        chk("stall_valid", {31'd0, disp_valid}, 32'd1);
        chk("stall_rd", {27'd0, disp_rd}, 32'd5);
        rdy_in = 1'b1;
        tick();
        chk("unstall_valid", {31'd0, disp_valid}, 32'd0);

        // Asynchronous reset between edges
        push(32'h00700293, 32'h700);
        tick();
        chk("pre_arst_valid", {31'd0, disp_valid}, 32'd1);
        #2 rst_in = 1'b1;
        #1;
        chk("arst_valid", {31'd0, disp_valid}, 32'd0);
        chk("arst_op", {26'd0, disp_op}, 32'd0);
        #1 rst_in = 1'b0;
        tick();

        // 6: MUL x1,x2,x3 on both instances
        push(32'h023100b3, 32'h800);
        tick();
        chk("mul_off_op", {26'd0, disp_op}, 32'd39);
        chk("mul_off_unit", {30'd0, disp_unit}, 32'd2);
        chk("mul_off_rd", {27'd0, disp_rd}, 32'd0);
        chk("mul_on_valid", {31'd0, m_disp_valid}, 32'd1);
        chk("mul_on_op", {26'd0, m_disp_op}, 32'd40);
        chk("mul_on_unit", {30'd0, m_disp_unit}, 32'd0);
        chk("mul_on_rd", {27'd0, m_disp_rd}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
